ddr_crc5_checker: RTL and testbench
===================================

Name: ddr_crc5_checker

Overview:
- Receive-side CRC-5 checker for the HDR-DDR datapath; counterpart to the transmit-side CRC-5 generator.
- Accumulates CRC-5 over the deserialized data bytes of one frame.
- Compares the result against the 5-bit CRC field received in the frame's CRC word.
- Reports pass/fail with a one-cycle done pulse to the receive controller.

Parameters:
SEED, 5'h1F, CRC register value loaded at frame start.
POLY, 5'h05, polynomial taps excluding x^5 (x^5+x^2+1).
CNT_W, 8, width of the received-byte counter.

Ports:
i_sys_clk  input  1  system clock, all logic on rising edge.
i_sys_rst  input  1  asynchronous reset, active-high.
i_enable  input  1  frame window; rising level in IDLE starts a frame, low aborts.
i_data_valid  input  1  i_parallel_data holds a received data byte this cycle.
i_parallel_data  input  8  received data byte, MSB is first on the wire.
i_crc_valid  input  1  i_crc_rx holds the received CRC field; ends the frame.
i_crc_rx  input  5  received CRC-5 value.
o_busy  output  1  high in ACCUM.
o_crc_done  output  1  one-cycle pulse: check result valid.
o_crc_error  output  1  mismatch or protocol error; valid from o_crc_done, held until next frame start.
o_crc_calc  output  5  accumulated CRC; held after done.
o_byte_cnt  output  CNT_W  bytes accumulated in the current/last frame.

Behaviour:
- Reset (async, i_sys_rst=1):
  - State goes to IDLE.
  - crc_reg=SEED.
  - o_busy=0, o_crc_done=0, o_crc_error=0, o_crc_calc=SEED, o_byte_cnt=0.
- Serial step with input bit d:
  - fb = crc[4]^d.
  - crc_next = {crc[3:0],1'b0} ^ (fb ? POLY : 5'h00).
- Byte update: eight serial steps, bit 7 first, computed combinationally in one cycle.
- States:
  - IDLE:
    - If i_enable=1, go to ACCUM.
    - On entry to ACCUM: crc_reg=SEED, o_byte_cnt=0, o_crc_error=0.
    - i_data_valid and i_crc_valid are ignored in IDLE.
  - ACCUM:
    - If i_enable=0: go to IDLE, no o_crc_done, crc/count held.
    - Else if i_crc_valid=1:
      - Latch i_crc_rx and go to CHECK.
      - If i_data_valid is also 1, the byte is NOT accumulated and a protocol error is flagged.
    - Else if i_data_valid=1:
      - crc_reg = byte_update(crc_reg, i_parallel_data).
      - o_byte_cnt increments, saturating at all-ones.
  - CHECK (one cycle):
    - o_crc_done=1.
    - o_crc_error=1 if any of:
      - latched CRC != crc_reg,
      - o_byte_cnt==0 (CRC word with no data),
      - a protocol error was flagged.
    - Next state is DONE.
  - DONE:
    - Stay while i_enable=1.
    - Go to IDLE when i_enable=0. A new frame requires i_enable low for at least one cycle.
- Latency: o_crc_done rises exactly 1 cycle after the cycle where i_crc_valid is sampled in ACCUM.
- o_crc_calc tracks crc_reg continuously.
- i_enable falling in the same cycle as i_crc_valid: the abort wins, and no done pulse is issued.
- Reset mid-frame: everything returns to reset values immediately, and no done pulse is issued.
- Back-to-back data bytes every cycle are supported. No backpressure: the block always accepts.

Test Plan:
- Frame with byte 0x00, then i_crc_rx=5'h0F → o_crc_calc=5'h0F; o_crc_done pulses 1 cycle later; o_crc_error=0; o_byte_cnt=1.
- Frame with byte 0xFF, then i_crc_rx=5'h1B → pass; repeat with i_crc_rx=5'h1A → o_crc_error=1.
- Frame with bytes 0x00, 0xFF on consecutive cycles, then i_crc_rx=5'h15 → pass; o_byte_cnt=2.
- i_crc_valid with no preceding bytes, i_crc_rx=5'h1F → o_crc_error=1 (empty frame); i_data_valid and i_crc_valid together in ACCUM → byte not counted, o_crc_error=1.
- Drop i_enable after one byte → no o_crc_done, state IDLE; next frame starts from SEED and passes with 0x00/5'h0F. Assert i_sys_rst mid-frame → all outputs at reset values in the same cycle.
- Send 2^CNT_W+3 bytes → o_byte_cnt saturates at all-ones; CRC still compared correctly against a model-computed value.

Source files
------------

// File: rtl/ddr_crc5_checker.sv
// Receive-side CRC-5 checker for the HDR-DDR datapath: accumulates CRC-5 over a
// frame's data bytes and compares it against the received CRC field.
module ddr_crc5_checker #(
    parameter logic [4:0] SEED  = 5'h1F,
    parameter logic [4:0] POLY  = 5'h05,
    parameter int         CNT_W = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_enable,
    input  logic             i_data_valid,
    input  logic [7:0]       i_parallel_data,
    input  logic             i_crc_valid,
    input  logic [4:0]       i_crc_rx,
    output logic             o_busy,
    output logic             o_crc_done,
    output logic             o_crc_error,
    output logic [4:0]       o_crc_calc,
    output logic [CNT_W-1:0] o_byte_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CHECK, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_crc;
    logic [4:0]         r_crc_rx;
    logic               r_proto_err;
    logic               r_crc_error;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               w_check_err;
    logic [4:0]         w_crc_byte;

    // Eight serial steps, wire-order MSB first, unrolled into one cycle.
    function automatic logic [4:0] f_byte_update(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] v;
        v = c;
        for (int i = 7; i >= 0; i--) begin
            v = {v[3:0], 1'b0} ^ ((v[4] ^ d[i]) ? POLY : 5'h00);
        end
        return v;
    endfunction

    assign w_crc_byte  = f_byte_update(r_crc, i_parallel_data);
    assign w_check_err = (r_crc_rx != r_crc) || (r_byte_cnt == '0) || r_proto_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_enable) w_state_nxt = S_ACCUM;
            S_ACCUM: begin
                if (!i_enable)        w_state_nxt = S_IDLE;
                else if (i_crc_valid) w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_DONE:  if (!i_enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_crc       <= SEED;
            r_crc_rx    <= '0;
            r_proto_err <= 1'b0;
            r_crc_error <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_crc       <= SEED;
                        r_byte_cnt  <= '0;
                        r_crc_error <= 1'b0;
                        r_proto_err <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (i_enable) begin
                        if (i_crc_valid) begin
                            r_crc_rx    <= i_crc_rx;
                            // A data byte colliding with the CRC word is dropped and flagged.
                            r_proto_err <= i_data_valid;
                        end else if (i_data_valid) begin
                            r_crc <= w_crc_byte;
                            if (r_byte_cnt != '1)
                                r_byte_cnt <= r_byte_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_CHECK: r_crc_error <= w_check_err;
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state == S_ACCUM);
    assign o_crc_done  = (r_state == S_CHECK);
    // During CHECK the verdict is shown directly; afterwards the registered copy holds it.
    assign o_crc_error = (r_state == S_CHECK) ? w_check_err : r_crc_error;
    assign o_crc_calc  = r_crc;
    assign o_byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_ddr_crc5_checker.sv
// Directed, table-driven bench for ddr_crc5_checker plus hand sequences for
// abort, mid-frame reset and counter saturation.
module tb_ddr_crc5_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, dv, cv;
    logic [7:0] data;
    logic [4:0] crc_rx;
    logic       busy, done, err;
    logic [4:0] calc;
    logic [7:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ddr_crc5_checker #(.SEED(5'h1F), .POLY(5'h05), .CNT_W(8)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_enable(en), .i_data_valid(dv),
        .i_parallel_data(data), .i_crc_valid(cv), .i_crc_rx(crc_rx),
        .o_busy(busy), .o_crc_done(done), .o_crc_error(err),
        .o_crc_calc(calc), .o_byte_cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              nb;
        logic [1:0][7:0] b;
        logic [4:0]      rx;
        logic            both;
        logic [4:0]      exp_calc;
        logic            exp_err;
        logic [7:0]      exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] model_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] v;
        logic       fb;
        v = c;
        for (int i = 7; i >= 0; i--) begin
            fb = v[4] ^ d[i];
            v  = {v[3:0], 1'b0};
            if (fb) v = v ^ 5'h05;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        en = 1'b1;
        tick();
        chk({v.name, "_busy"}, busy, 1'b1);
        for (int k = 0; k < v.nb; k++) begin
            dv = 1'b1; data = v.b[k];
            tick();
        end
        dv = 1'b0;
        chk({v.name, "_nodone_pre"}, done, 1'b0);
        cv = 1'b1; crc_rx = v.rx;
        if (v.both) begin dv = 1'b1; data = 8'hFF; end
        tick();
        cv = 1'b0; dv = 1'b0;
        chk({v.name, "_done"}, done, 1'b1);
        chk({v.name, "_err"},  err,  v.exp_err);
        chk({v.name, "_calc"}, calc, v.exp_calc);
        chk({v.name, "_cnt"},  cnt,  v.exp_cnt);
        tick();
        chk({v.name, "_done_pulse"}, done, 1'b0);
        chk({v.name, "_err_held"},   err,  v.exp_err);
        en = 1'b0;
        tick();
        chk({v.name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [4:0] mcrc;
        vecs[0] = '{"b00_pass",   1, {8'h00, 8'h00}, 5'h0F, 1'b0, 5'h0F, 1'b0, 8'd1};
        vecs[1] = '{"bFF_pass",   1, {8'h00, 8'hFF}, 5'h1B, 1'b0, 5'h1B, 1'b0, 8'd1};
        vecs[2] = '{"bFF_fail",   1, {8'h00, 8'hFF}, 5'h1A, 1'b0, 5'h1B, 1'b1, 8'd1};
        vecs[3] = '{"b00FF_pass", 2, {8'hFF, 8'h00}, 5'h15, 1'b0, 5'h15, 1'b0, 8'd2};
        vecs[4] = '{"empty",      0, {8'h00, 8'h00}, 5'h1F, 1'b0, 5'h1F, 1'b1, 8'd0};
        vecs[5] = '{"collide",    1, {8'h00, 8'h00}, 5'h0F, 1'b1, 5'h0F, 1'b1, 8'd1};

        rst = 1'b1; en = 1'b0; dv = 1'b0; cv = 1'b0; data = '0; crc_rx = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err",  err,  1'b0);
        chk("rst_calc", calc, 5'h1F);
        chk("rst_cnt",  cnt,  8'd0);
        rst = 1'b0;
        tick();

        // Inputs in IDLE must be ignored.
        dv = 1'b1; data = 8'hA5; cv = 1'b1;
        tick();
        dv = 1'b0; cv = 1'b0;
        chk("idle_ignore_cnt",  cnt,  8'd0);
        chk("idle_ignore_done", done, 1'b0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort after one byte: no done, count/crc held.
        en = 1'b1; tick();
        dv = 1'b1; data = 8'h00; tick();
        dv = 1'b0; en = 1'b0; tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_cnt",  cnt,  8'd1);
        chk("abort_calc", calc, 5'h0F);
        tick();
        chk("abort_done_late", done, 1'b0);

        // Abort in the same cycle as the CRC word.
        en = 1'b1; tick();
        dv = 1'b1; data = 8'hFF; tick();
        dv = 1'b0; en = 1'b0; cv = 1'b1; crc_rx = 5'h1B; tick();
        cv = 1'b0;
        chk("abort_crc_done", done, 1'b0);
        chk("abort_crc_busy", busy, 1'b0);
        tick();
        chk("abort_crc_done2", done, 1'b0);

        run_vec(vecs[0]);

        // Reset mid-frame takes effect without a clock edge.
        en = 1'b1; tick();
        dv = 1'b1; data = 8'hFF; tick();
        dv = 1'b0;
        rst = 1'b1; #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err",  err,  1'b0);
        chk("mrst_calc", calc, 5'h1F);
        chk("mrst_cnt",  cnt,  8'd0);
        en = 1'b0; #2; rst = 1'b0;
        tick();
        chk("mrst_after_done", done, 1'b0);

        // Counter saturation over 2^8+3 bytes.
        en = 1'b1; tick();
        mcrc = 5'h1F;
        for (int k = 0; k < 259; k++) begin
            dv = 1'b1; data = 8'((k * 37 + 11) & 8'hFF);
            mcrc = model_byte(mcrc, data);
            tick();
        end
        dv = 1'b0;
        chk("sat_cnt", cnt, 8'hFF);
        cv = 1'b1; crc_rx = mcrc; tick();
        cv = 1'b0;
        chk("sat_done", done, 1'b1);
        chk("sat_calc", calc, mcrc);
        chk("sat_err",  err,  1'b0);
        en = 1'b0; tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
